// File: rtl/fpu_issue_queue.sv
// FIFO issue queue in front of the FPU: buffers command/operand requests,
// drops illegal commands with a one-cycle error pulse, and supports flush.
module fpu_issue_queue #(
  parameter int bitness = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_command,
  input  logic [bitness-1:0] in_data_a,
  input  logic [bitness-1:0] in_data_b,
  output logic               input_rdy,
  input  logic               input_ack,
  output logic [bitness-1:0] data_a,
  output logic [bitness-1:0] data_b,
  output logic [3:0]         command,
  output logic [CNT_W-1:0]   count,
  output logic               cmd_error
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [3:0]         mem_cmd_r [DEPTH];
  logic [bitness-1:0] mem_a_r   [DEPTH];
  logic [bitness-1:0] mem_b_r   [DEPTH];

  logic [PTR_W-1:0] wp_r;
  logic [PTR_W-1:0] rp_r;
  logic [CNT_W-1:0] count_r;
  logic             cmd_error_r;

  logic push_s;
  logic pop_s;
  logic illegal_s;
  logic [CNT_W-1:0] count_nxt_s;

  // Only add, sub, mul and div are accepted by the FPU.
  function automatic logic cmd_legal(input logic [3:0] cmd);
    return (cmd <= 4'd3);
  endfunction

  // Handshake decode from registered occupancy; no input-to-output bypass.
  always_comb begin
    in_ready  = (count_r != CNT_W'(DEPTH));
    input_rdy = (count_r != {CNT_W{1'b0}});
    push_s    = in_valid && in_ready && cmd_legal(in_command);
    illegal_s = in_valid && in_ready && !cmd_legal(in_command);
    pop_s     = input_rdy && input_ack;
  end

  // Occupancy next-state: simultaneous push and pop leave count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and error-pulse registers; reset beats flush beats traffic.
  always_ff @(posedge clock) begin
    if (reset) begin
      wp_r        <= {PTR_W{1'b0}};
      rp_r        <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      cmd_error_r <= 1'b0;
    end else if (flush) begin
      wp_r        <= {PTR_W{1'b0}};
      rp_r        <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      cmd_error_r <= 1'b0;
    end else begin
      if (push_s) begin
        wp_r <= wp_r + PTR_W'(1);
      end else begin
        wp_r <= wp_r;
      end
      if (pop_s) begin
        rp_r <= rp_r + PTR_W'(1);
      end else begin
        rp_r <= rp_r;
      end
      count_r     <= count_nxt_s;
      cmd_error_r <= illegal_s;
    end
  end

  // Entry storage is not reset; a push coinciding with flush or reset is discarded.
  always_ff @(posedge clock) begin
    if (push_s && !flush && !reset) begin
      mem_cmd_r[wp_r] <= in_command;
      mem_a_r[wp_r]   <= in_data_a;
      mem_b_r[wp_r]   <= in_data_b;
    end
  end

  // Head entry presented straight from storage at the read pointer.
  always_comb begin
    command   = mem_cmd_r[rp_r];
    data_a    = mem_a_r[rp_r];
    data_b    = mem_b_r[rp_r];
    count     = count_r;
    cmd_error = cmd_error_r;
  end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed scoreboard bench for fpu_issue_queue.
module tb_fpu_issue_queue;

  localparam int BW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_command = 4'd0;
  logic [BW-1:0]     in_data_a = '0;
  logic [BW-1:0]     in_data_b = '0;
  logic              input_rdy;
  logic              input_ack = 1'b0;
  logic [BW-1:0]     data_a;
  logic [BW-1:0]     data_b;
  logic [3:0]        command;
  logic [CNT_W-1:0]  count;
  logic              cmd_error;

  fpu_issue_queue #(.bitness(BW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_command(in_command),
    .in_data_a(in_data_a), .in_data_b(in_data_b),
    .input_rdy(input_rdy), .input_ack(input_ack),
    .data_a(data_a), .data_b(data_b), .command(command),
    .count(count), .cmd_error(cmd_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]    cmd;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
  } entry_t;

  entry_t sb[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     m_count = 0;
  logic   exp_err = 1'b0;
  bit     model_valid = 1'b0;
  int     dut_pops = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, advance the model, then step.
  task automatic tick();
    bit push_m, pop_m, ill_m;
    entry_t e;
    if (model_valid) begin
      chk("count", 64'(count), 64'(m_count));
      chk("input_rdy", 64'(input_rdy), 64'(m_count != 0));
      chk("in_ready", 64'(in_ready), 64'(m_count != DEPTH));
      chk("cmd_error", 64'(cmd_error), 64'(exp_err));
      if (m_count != 0) begin
        chk("head_cmd", 64'(command), 64'(sb[0].cmd));
        chk("head_a", 64'(data_a), 64'(sb[0].a));
        chk("head_b", 64'(data_b), 64'(sb[0].b));
      end
    end
    if (input_rdy === 1'b1 && input_ack === 1'b1 && !reset) dut_pops++;
    if (reset) begin
      sb.delete();
      m_count = 0;
      exp_err = 1'b0;
      model_valid = 1'b1;
    end else if (flush) begin
      sb.delete();
      m_count = 0;
      exp_err = 1'b0;
    end else begin
      pop_m  = (m_count != 0) && input_ack;
      push_m = in_valid && (m_count != DEPTH) && (in_command <= 4'd3);
      ill_m  = in_valid && (m_count != DEPTH) && (in_command > 4'd3);
      if (pop_m) void'(sb.pop_front());
      if (push_m) begin
        e.cmd = in_command; e.a = in_data_a; e.b = in_data_b;
        sb.push_back(e);
      end
      m_count = m_count + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
      exp_err = ill_m;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [BW-1:0] a, input logic [BW-1:0] b);
    in_valid = v; in_command = c; in_data_a = a; in_data_b = b;
  endtask

  initial begin
    int pops0;
    // Reset
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single push, hold without ack
    drive(1'b1, 4'd0, 32'h3F800000, 32'h40000000);
    tick();
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    chk("t1_rdy", 64'(input_rdy), 64'd1);
    chk("t1_a", 64'(data_a), 64'h3F800000);
    chk("t1_b", 64'(data_b), 64'h40000000);
    chk("t1_cmd", 64'(command), 64'd0);
    chk("t1_count", 64'(count), 64'd1);
    repeat (10) tick();
    input_ack = 1'b1; tick(); input_ack = 1'b0; tick();

    // Fill, overflow attempt, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i));
      tick();
    end
    drive(1'b1, 4'd1, 32'hDEAD0005, 32'hBEEF0005);
    tick();
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    chk("t2_full_count", 64'(count), 64'd4);
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    input_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_order_cmd", 64'(command), 64'(i));
      tick();
    end
    input_ack = 1'b0;
    chk("t2_empty", 64'(input_rdy), 64'd0);
    tick();

    // Illegal commands, including back-to-back
    drive(1'b1, 4'hA, 32'h11111111, 32'h22222222);
    tick();
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    chk("t3_err", 64'(cmd_error), 64'd1);
    chk("t3_count", 64'(count), 64'd0);
    tick();
    chk("t3_err_clr", 64'(cmd_error), 64'd0);
    drive(1'b1, 4'hF, 32'h1, 32'h2); tick();
    drive(1'b1, 4'h4, 32'h3, 32'h4); tick();
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    chk("t3_b2b", 64'(cmd_error), 64'd1);
    tick();

    // Streaming ramp with continuous ack
    pops0 = dut_pops;
    input_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'(i % 4), 32'd100 + 32'(i), 32'hFFFF0000 - 32'(i));
      tick();
    end
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    tick();
    input_ack = 1'b0;
    chk("t4_pops", 64'(dut_pops - pops0), 64'd20);
    tick();

    // Flush with concurrent push and ack
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd2, 32'h5000 + 32'(i), 32'h6000 + 32'(i));
      tick();
    end
    drive(1'b1, 4'd3, 32'h77777777, 32'h88888888);
    flush = 1'b1; input_ack = 1'b1;
    tick();
    flush = 1'b0; input_ack = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_rdy", 64'(input_rdy), 64'd0);
    chk("t5_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 4'd1, 32'hCAFEF00D, 32'h0BADBEEF);
    tick();
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    chk("t5_head", 64'(data_a), 64'hCAFEF00D);
    input_ack = 1'b1; tick(); input_ack = 1'b0; tick();

    // Reset mid-transfer
    drive(1'b1, 4'd0, 32'hA, 32'hB); tick();
    drive(1'b1, 4'd1, 32'hC, 32'hD); tick();
    drive(1'b1, 4'hB, 32'h0, 32'h0);
    input_ack = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; input_ack = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_rdy", 64'(input_rdy), 64'd0);
    chk("t6_err", 64'(cmd_error), 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
